// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store controller: FSM states, error codes
// and the funct3 size/sign encodings used on the execute-stage interface.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  localparam logic [1:0] LSU_ERR_OK       = 2'b00;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_ERR_RANGE    = 2'b10;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b11;

  localparam logic [2:0] FUNC_LB  = 3'b000;
  localparam logic [2:0] FUNC_LH  = 3'b001;
  localparam logic [2:0] FUNC_LW  = 3'b010;
  localparam logic [2:0] FUNC_LBU = 3'b100;
  localparam logic [2:0] FUNC_LHU = 3'b101;
  localparam logic [2:0] FUNC_SB  = 3'b000;
  localparam logic [2:0] FUNC_SH  = 3'b001;
  localparam logic [2:0] FUNC_SW  = 3'b010;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables, replicated store data, extended
// load data and legality flags from funct3 and the low address bits.
module lsu_lane_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic [1:0]  size_m1,
  output logic        illegal,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    rdata_ext  = 32'h0;
    size_m1    = 2'd0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    shifted    = rdata >> {addr_lo, 3'b000};

    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        size_m1   = 2'd0;
      end
      2'b01: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
        size_m1    = 2'd1;
        misaligned = addr_lo[0];
      end
      2'b10: begin
        be         = 4'b1111;
        size_m1    = 2'd3;
        misaligned = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase

    // Unsigned variants exist only for byte/half loads.
    if (funct3[2] && (store || funct3[1]))
      illegal = 1'b1;

    case (funct3)
      FUNC_LB:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      FUNC_LH:  rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      FUNC_LW:  rdata_ext = rdata;
      FUNC_LBU: rdata_ext = {24'h0, shifted[7:0]};
      FUNC_LHU: rdata_ext = {16'h0, shifted[15:0]};
      default:  rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Handshaked multi-cycle load/store controller between execute and writeback,
// driving a word-wide bus with byte enables and a bounded ack wait.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic [1:0]        rsp_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [1:0]        state_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH_BYTES - 1);

  // Both handshakes are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the producer holds its payload until then.
  lsu_state_t       state;
  logic             store_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       funct3_sel;
  logic             store_sel;
  logic [1:0]       addr_lo_sel;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  logic [31:0]      rdata_ext;
  logic [1:0]       size_m1;
  logic             illegal;
  logic             misaligned;
  logic [ADDR_W:0]  last_byte;
  logic             out_of_range;

  assign req_ready_o = (state == ST_IDLE);
  assign state_o     = state;

  // One aligner serves both phases: live request in IDLE, latched one after.
  assign funct3_sel  = (state == ST_IDLE) ? req_funct3_i    : funct3_q;
  assign store_sel   = (state == ST_IDLE) ? req_store_i     : store_q;
  assign addr_lo_sel = (state == ST_IDLE) ? req_addr_i[1:0] : addr_lo_q;

  lsu_lane_align u_align (
    .funct3     (funct3_sel),
    .store      (store_sel),
    .addr_lo    (addr_lo_sel),
    .wdata      (req_wdata_i),
    .rdata      (mem_rdata_i),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext),
    .size_m1    (size_m1),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

  assign last_byte    = {1'b0, req_addr_i} + {{(ADDR_W - 1){1'b0}}, size_m1};
  assign out_of_range = (last_byte > LAST_ADDR);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      store_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      cnt         <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'h0;
      rsp_err_o   <= LSU_ERR_OK;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= 4'b0000;
      mem_wdata_o <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            store_q   <= req_store_i;
            funct3_q  <= req_funct3_i;
            addr_lo_q <= req_addr_i[1:0];
            cnt       <= '0;
            if (illegal || misaligned) begin
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= 32'h0;
              rsp_err_o   <= LSU_ERR_MISALIGN;
              state       <= ST_RESP;
            end else if (out_of_range) begin
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= 32'h0;
              rsp_err_o   <= LSU_ERR_RANGE;
              state       <= ST_RESP;
            end else begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= req_store_i;
              mem_addr_o  <= {req_addr_i[ADDR_W-1:2], 2'b00};
              mem_be_o    <= be;
              mem_wdata_o <= wdata_rep;
              state       <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          // Ack is checked first so an ack in the last allowed cycle still wins.
          if (mem_ack_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= store_q ? 32'h0 : rdata_ext;
            rsp_err_o   <= LSU_ERR_OK;
            state       <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= LSU_ERR_TIMEOUT;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Parametrised load/store controller that replaces the single-cycle data-memory stage with a handshaked, multi-cycle access path. Accepts one load or store from the execute stage, checks alignment and address range, drives a word-wide memory bus with byte enables and variable-latency acknowledge, applies load extension, and returns data plus an error code. Sits between execute and writeback; the memory side connects to the data RAM or any wait-stated slave.

## Interface
- ADDR_W, 32, byte-address width
- DEPTH_BYTES, 1024, addressable bytes; power of two, ≥ 4
- TIMEOUT, 15, max cycles `mem_req_o` is held without ack; ≥ 1

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  access request
- req_ready_o  out  1  controller can accept
- req_store_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  size/sign, existing `FUNC_*` encodings
- req_addr_i  in  ADDR_W  byte address (valE)
- req_wdata_i  in  32  store data (valA)
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  consumer takes response
- rsp_rdata_o  out  32  extended load data; 0 for stores/errors
- rsp_err_o  out  2  00 ok, 01 misaligned/illegal funct3, 10 out of range, 11 timeout
- mem_req_o  out  1  bus request
- mem_we_o  out  1  write
- mem_addr_o  out  ADDR_W  word address (bits [1:0] = 0)
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated store data
- mem_ack_i  in  1  slave completion; rdata valid same cycle
- mem_rdata_i  in  32  read word

## Operation
- FSM: IDLE, BUS, RESP. `req_ready_o` = (state == IDLE).
- IDLE: on req_valid_i & req_ready_o, register request. Checks, priority order: illegal funct3 (loads: LB/LH/LW/LBU/LHU; stores: SB/SH/SW) or misaligned (half: addr[0]≠0; word: addr[1:0]≠0) → err 01; last byte addr+size−1 > DEPTH_BYTES−1 → err 10. Error → RESP without bus access; else → BUS.
- BUS: mem_req_o=1, outputs stable until ack. mem_ack_i sampled high → capture data, err 00, → RESP. Counter counts BUS cycles; ack not seen by cycle TIMEOUT → drop mem_req_o, err 11, → RESP. Ack in the final allowed cycle wins over timeout.
- RESP: rsp_valid_o=1, data/err held stable; rsp_ready_i high → IDLE. No accept in the same cycle.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- Load: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- mem_ack_i outside BUS ignored.

## Timing
- Reset: state IDLE, req_ready_o=1 after reset deasserts; rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=00, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0, counter 0.
- Accept at edge N; mem_req_o high from N to the ack edge. Ack at first BUS cycle → rsp_valid_o after edge N+2 (min latency 2). Error path: rsp_valid_o after edge N+1.
- Timeout: ack absent for TIMEOUT BUS cycles → mem_req_o low and rsp_valid_o high together.
- Reset mid-BUS: mem_req_o drops immediately (async); the in-flight access is abandoned, late ack ignored.
- Throughput: one access per ≥ 3 cycles.

## Structure
- define.v gains: LSU state encodings, LSU_ERR_OK/MISALIGN/RANGE/TIMEOUT constants; reuses `FUNC_*`.
- Sub-module lsu_lane_align (combinational): funct3 + addr[1:0] + data → byte enables, replicated wdata, extended rdata, illegal/misaligned flags.
- Timeout counter width $clog2(TIMEOUT+1).

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF, ack 1st cycle → mem_be_o=1111, mem_addr_o=0x10, rsp_valid_o 2 cycles after accept, err 00.
- LB addr 0x13, mem_rdata_i=0x80FF_0000 → rsp_rdata_o=0xFFFFFF80; LBU same → 0x00000080; LH addr 0x12 → 0xFFFF80FF.
- SH addr 0x11 → no mem_req_o, err 01 one cycle after accept; LW addr 0x3FE (DEPTH_BYTES=1024) → err 01; LW addr 0x400 → err 10.
- Ack withheld (TIMEOUT=15) → mem_req_o high 15 cycles then low, err 11; ack in 15th cycle → err 00 with data.
- rsp_ready_i low 5 cycles → rsp data/err stable, req_ready_o low; then accept of next request only after return to IDLE.
- rst_n_i asserted during BUS → mem_req_o/rsp_valid_o 0 immediately; ack after release ignored, req_ready_o=1.
